// File: rtl/biquad_filter.sv
// biquad_filter: Direct Form I biquad sharing one multiplier across CHANNELS channels,
// with a shadow coefficient bank that is copied to the active bank when a sample is accepted.
module biquad_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int COEF_FRAC = 15,
  parameter int CHANNELS = 2,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_chan,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_chan,
  input  logic                     coef_wr,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     bypass,
  input  logic                     hist_clr
);
  localparam int ACC_W = DATA_W + COEF_W + 3;
  localparam int P_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] ONE = COEF_W'(2 ** COEF_FRAC);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, DONE} state_t;
  state_t state, state_nx;
  logic accept, ch_ok, clr_now, wr_ok, busy, coef_pend, clr_pend;
  logic [CH_W-1:0] chan;
  logic signed [COEF_W-1:0] act [5];
  logic signed [COEF_W-1:0] shd [5];
  logic signed [COEF_W-1:0] c;
  logic signed [DATA_W-1:0] x0, d, hx1, hx2, hy1, hy2, y;
  logic signed [DATA_W-1:0] x1 [CHANNELS];
  logic signed [DATA_W-1:0] x2 [CHANNELS];
  logic signed [DATA_W-1:0] y1 [CHANNELS];
  logic signed [DATA_W-1:0] y2 [CHANNELS];
  logic signed [P_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, rnd;
  always_comb begin
    in_ready = state == IDLE;
    accept = in_valid && in_ready;
    busy = state != IDLE && state != DONE;
    state_nx = accept ? MAC0 : !busy ? IDLE : state_t'(state + 3'd1);
    ch_ok = 32'(chan) < CHANNELS;
    hx1 = ch_ok ? x1[chan] : '0;
    hx2 = ch_ok ? x2[chan] : '0;
    hy1 = ch_ok ? y1[chan] : '0;
    hy2 = ch_ok ? y2[chan] : '0;
    c = state == MAC0 ? act[0] : state == MAC1 ? act[1] : state == MAC2 ? act[2] :
        state == MAC3 ? act[3] : act[4];
    d = state == MAC0 ? x0 : state == MAC1 ? hx1 : state == MAC2 ? hx2 :
        state == MAC3 ? hy1 : hy2;
    prod = P_W'(c) * P_W'(d);
    rnd = (acc + HALF) >>> COEF_FRAC;
    y = bypass ? x0 : rnd > MAXV ? MAXV[DATA_W-1:0] : rnd < MINV ? MINV[DATA_W-1:0] : rnd[DATA_W-1:0];
    wr_ok = coef_wr && coef_addr < 3'd5;
    clr_now = state == IDLE ? hist_clr : state == DONE && (hist_clr || clr_pend);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      x0 <= '0;
      chan <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      coef_pend <= 1'b0;
      clr_pend <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        act[i] <= i == 0 ? ONE : '0;
        shd[i] <= i == 0 ? ONE : '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      state <= state_nx;
      out_valid <= state == DONE;
      coef_pend <= wr_ok || (coef_pend && !accept);
      clr_pend <= busy && (clr_pend || hist_clr);
      if (wr_ok) shd[coef_addr] <= coef_data;
      if (accept) begin
        x0 <= in_data;
        chan <= in_chan;
        acc <= '0;
        if (coef_pend) act <= shd;
      end
      // feedback terms are subtracted so a1/a2 keep their textbook sign
      if (busy) acc <= state == MAC3 || state == MAC4 ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
      if (state == DONE) begin
        out_data <= y;
        out_chan <= chan;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (clr_now) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end else if (state == DONE && ch_ok && chan == CH_W'(i)) begin
          x2[i] <= x1[i];
          x1[i] <= x0;
          y2[i] <= y1[i];
          y1[i] <= y;
        end
      end
    end
  end
endmodule

// File: tb/tb_biquad_filter.sv
// tb_biquad_filter: scoreboard bench for biquad_filter; expected outputs are hand-derived
// constants queued at accept time and compared when out_valid pulses.
module tb_biquad_filter;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, coef_wr = 1'b0, bypass = 1'b0, hist_clr = 1'b0;
  logic in_ready, out_valid;
  logic signed [15:0] in_data = '0;
  logic signed [15:0] out_data;
  logic [0:0] in_chan = '0;
  logic [0:0] out_chan;
  logic [2:0] coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  int n_chk = 0, n_pass = 0;
  typedef struct {int ch; int d;} exp_t;
  exp_t sb[$];
  biquad_filter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chan(in_chan), .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .bypass(bypass),
    .hist_clr(hist_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        check("out_data", out_data, sb[0].d);
        check("out_chan", out_chan, sb[0].ch);
        void'(sb.pop_front());
      end
    end
  end
  task automatic send(input int ch, input int x, input int e, input bit push = 1'b1);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data = 16'(x);
    in_chan = 1'(ch);
    @(posedge clk);
    if (push) sb.push_back('{ch, e});
    #1 in_valid = 1'b0;
  endtask
  task automatic wc(input int addr, input int val);
    @(negedge clk);
    coef_wr = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 18'(val);
    @(posedge clk);
    #1 coef_wr = 1'b0;
  endtask
  task automatic setc(input int b0, input int b1, input int b2, input int a1, input int a2);
    wc(0, b0);
    wc(1, b1);
    wc(2, b2);
    wc(3, a1);
    wc(4, a2);
  endtask
  task automatic clr();
    @(negedge clk);
    hist_clr = 1'b1;
    @(posedge clk);
    #1 hist_clr = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    int lows;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    // unity default, latency and busy window
    send(0, 32767, 32767);
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!in_ready && !out_valid) lows++;
    end
    check("busy_cycles", lows, 6);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_ready", in_ready, 1);
    drain();
    setc(16384, 16384, 0, 0, 0);
    clr();
    send(0, 1000, 500);
    send(0, 3000, 2000);
    send(0, 3000, 3000);
    drain();
    // saturation, and saturated y history feeding back
    setc(65536, 0, 0, 0, 0);
    clr();
    send(0, 20000, 32767);
    send(0, -20000, -32768);
    drain();
    setc(0, 0, 0, -16384, 0);
    send(0, 123, -16384);
    drain();
    // feedback with interleaved channels
    setc(32768, 0, 0, -16384, 0);
    clr();
    send(1, 16384, 16384);
    send(0, 0, 0);
    send(1, 0, 8192);
    send(0, 0, 0);
    send(1, 0, 4096);
    send(1, 0, 2048);
    drain();
    // second-order taps b2 / a2
    setc(0, 0, 32768, 0, -16384);
    clr();
    send(0, 100, 0);
    send(0, 0, 0);
    send(0, 0, 100);
    send(0, 0, 0);
    send(0, 0, 50);
    drain();
    // coefficient write during MAC2 must not disturb the running sample
    setc(32768, 0, 0, 0, 0);
    clr();
    send(0, 1000, 1000);
    repeat (2) @(negedge clk);
    wc(0, 0);
    send(0, 777, 0);
    drain();
    // hist_clr while busy lands after the current output
    setc(32768, 0, 0, -16384, 0);
    clr();
    send(1, 16384, 16384);
    send(1, 0, 8192);
    repeat (2) @(negedge clk);
    clr();
    send(1, 16384, 16384);
    send(1, 0, 8192);
    drain();
    // reset in MAC3 discards the in-flight sample
    send(0, 5000, 0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    send(0, 1234, 1234);
    drain();
    // round half up
    setc(16384, 0, 0, 0, 0);
    send(0, 3, 2);
    send(0, -3, -1);
    drain();
    // bypass passes x but history still advances
    setc(16384, 16384, 0, 0, 0);
    bypass = 1'b1;
    send(1, 800, 800);
    drain();
    bypass = 1'b0;
    send(1, 0, 400);
    drain();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
